// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock.
// Operands shift down one chunk per cycle; carry is registered between chunks.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic             ovf_chunk;

    // A new operation may begin whenever no chunks are in flight.
    assign accept = start && (state != RUN);
    assign last   = (idx_q == LAST_IDX);

    // The current chunk always sits in the low bits of the operand registers,
    // so once the last chunk is reached its top bit is the operand MSB.
    assign a_chunk = a_q[CHUNK-1:0];
    assign b_chunk = b_q[CHUNK-1:0];

    assign {c_chunk, s_chunk} = {1'b0, a_chunk}
                              + {1'b0, b_chunk}
                              + {{CHUNK{1'b0}}, carry_q};

    assign ovf_chunk = (a_chunk[CHUNK-1] == b_chunk[CHUNK-1])
                    && (s_chunk[CHUNK-1] != a_chunk[CHUNK-1]);

    generate
        if (NUM_CHUNKS > 1) begin : g_shift
            assign a_shift = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
            assign b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        end else begin : g_noshift
            assign a_shift = a_q;
            assign b_shift = b_q;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = accept ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-chunk add and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum[i*CHUNK +: CHUNK] <= s_chunk;
                end
            end
            a_q     <= a_shift;
            b_q     <= b_shift;
            carry_q <= c_chunk;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                cout     <= c_chunk;
                overflow <= ovf_chunk;
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed checks of the 8-bit chunked adder.
// Four instances (CHUNK = 2, 1, 4, 8) share one set of inputs.
module tb_chunked_serial_adder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;

    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] cout_v;
    logic [3:0] ovf_v;
    logic [7:0] sum_v [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
        .cout(cout_v[0]), .overflow(ovf_v[0])
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
        .cout(cout_v[1]), .overflow(ovf_v[1])
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) dut_c4 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
        .cout(cout_v[2]), .overflow(ovf_v[2])
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[3]), .done(done_v[3]), .sum(sum_v[3]),
        .cout(cout_v[3]), .overflow(ovf_v[3])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch on the main instance and wait for its done (bounded).
    // Call just after a falling edge; returns on the done cycle.
    task automatic run(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is,
                       output int lat, output int busy_n);
        a = ia;
        b = ib;
        cin = ic;
        sub = is;
        start = 1'b1;
        lat = 0;
        busy_n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy_v[0]) busy_n++;
            if (done_v[0]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag,
                            input logic [7:0] ia, input logic [7:0] ib,
                            input logic ic, input logic is,
                            input logic [7:0] es, input logic ec,
                            input logic eo);
        int lat;
        int bn;
        run(ia, ib, ic, is, lat, bn);
        check({tag, " latency"}, lat, 5);
        check({tag, " busy cycles"}, bn, 4);
        check({tag, " sum"}, sum_v[0], es);
        check({tag, " cout"}, cout_v[0], ec);
        check({tag, " overflow"}, ovf_v[0], eo);
        @(negedge clock);
        check({tag, " done width"}, done_v[0], 1'b0);
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic       vs;
    } vec_t;

    vec_t sweep [6] = '{
        '{8'h3C, 8'hA7, 1'b1, 1'b0},
        '{8'h64, 8'h64, 1'b0, 1'b0},
        '{8'h9D, 8'h9D, 1'b1, 1'b0},
        '{8'h12, 8'h34, 1'b0, 1'b1},
        '{8'hC8, 8'h4B, 1'b1, 1'b1},
        '{8'h00, 8'h00, 1'b0, 1'b1}
    };

    int nch [4] = '{4, 8, 2, 1};

    initial begin
        int lat;
        int bn;
        int k;
        int lats [4];
        logic [7:0] beff;
        logic [8:0] full;
        logic [7:0] es;
        logic       eo;

        reset_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (2) @(negedge clock);
        check("reset busy", busy_v[0], 1'b0);
        check("reset done", done_v[0], 1'b0);
        check("reset sum", sum_v[0], 8'h00);
        check("reset cout", cout_v[0], 1'b0);
        check("reset ovf", ovf_v[0], 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        op_check("add 2A+15+1", 8'h2A, 8'h15, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        op_check("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op_check("add 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op_check("sub 05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op_check("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start pulsed mid-operation must be ignored.
        a = 8'h2A;
        b = 8'h15;
        cin = 1'b1;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 3;
        while (!done_v[0] && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("ignore latency", k, 5);
        check("ignore sum", sum_v[0], 8'h40);
        check("ignore cout", cout_v[0], 1'b0);

        // Back-to-back start during the done cycle.
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("b2b busy", busy_v[0], 1'b1);
        check("b2b done low", done_v[0], 1'b0);
        check("b2b old sum", sum_v[0], 8'h40);
        k = 1;
        while (!done_v[0] && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("b2b latency", k, 5);
        check("b2b sum", sum_v[0], 8'h30);
        @(negedge clock);

        // Reset in the middle of AA+55.
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("pre-reset busy", busy_v[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort busy", busy_v[0], 1'b0);
        check("abort done", done_v[0], 1'b0);
        check("abort sum", sum_v[0], 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        op_check("after abort", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Let every instance drain before the width sweep.
        repeat (12) @(negedge clock);

        foreach (sweep[v]) begin
            beff = sweep[v].vs ? ~sweep[v].vb : sweep[v].vb;
            full = {1'b0, sweep[v].va} + {1'b0, beff}
                 + {8'h00, (sweep[v].vs ? 1'b1 : sweep[v].vc)};
            es = full[7:0];
            eo = (sweep[v].va[7] == beff[7]) && (es[7] != sweep[v].va[7]);
            a = sweep[v].va;
            b = sweep[v].vb;
            cin = sweep[v].vc;
            sub = sweep[v].vs;
            start = 1'b1;
            lats = '{0, 0, 0, 0};
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                start = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (done_v[i] && lats[i] == 0) lats[i] = c;
                end
                if (lats[0] != 0 && lats[1] != 0 &&
                    lats[2] != 0 && lats[3] != 0) break;
            end
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sweep%0d n%0d latency", v, nch[i]),
                      lats[i], nch[i] + 1);
                check($sformatf("sweep%0d n%0d sum", v, nch[i]),
                      sum_v[i], es);
                check($sformatf("sweep%0d n%0d cout", v, nch[i]),
                      cout_v[i], full[8]);
                check($sformatf("sweep%0d n%0d ovf", v, nch[i]),
                      ovf_v[i], eo);
            end
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised successor to the 4-bit combinational parallel adder.
- Adds or subtracts two WIDTH-bit operands over NUM_CHUNKS = WIDTH/CHUNK clock cycles, CHUNK bits per cycle, with a registered carry between chunks.
- Start/busy/done handshake, add/subtract mode, carry-out and signed overflow.
- Used where a wide adder would break timing or area and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled on rising edge.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  mode: 0 = a+b+cin, 1 = a−b (a + ~b + 1); captured on accepted start.
- busy  out  1  high while chunks are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; chunk index and carry register cleared.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted in IDLE or DONE. On that edge:
  - capture A=a and B_eff = sub ? ~b : b;
  - carry = sub ? 1 : cin;
  - idx=0, state→RUN.
- Start while in RUN is ignored, with no effect on the current operation.
- RUN: each edge adds chunk idx:
  - {c, s} = A[idx] + B_eff[idx] + carry, each term CHUNK bits wide;
  - write s into sum[idx*CHUNK +: CHUNK]; carry←c; idx←idx+1;
  - on the last chunk (idx = NUM_CHUNKS−1): state→DONE, cout←c, overflow←(A msb == B_eff msb) && (final sum msb != A msb).
- busy=1 exactly while state=RUN.
- DONE: done=1 for exactly one cycle, then state→IDLE unless start was accepted on that edge.
- sum/cout/overflow hold their values from DONE until the next accepted start.
- sum bits are overwritten chunk by chunk during RUN; they are not valid until done.
- Latency: start accepted at edge E0; chunks processed at edges E1..EN (N=NUM_CHUNKS); done high in the cycle following EN.
- With no back-to-back start, an operation occupies N+1 cycles from start acceptance to done high.
- Back-to-back: start=1 during the DONE cycle is accepted.
  - done is still high that cycle.
  - Next state is RUN, busy=1 the following cycle.
  - The previous result remains on sum until chunk 0 of the new operation overwrites it.
- CHUNK=WIDTH degenerates to N=1: one RUN cycle, then DONE.
- Reset asserted mid-RUN aborts the operation immediately.
  - All outputs return to reset values.
  - A start in the first cycle after deassertion is accepted normally.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=8, CHUNK=2, N=4):
- a=0x2A, b=0x15, cin=1, sub=0 → after 4 busy cycles: sum=0x40, cout=0, overflow=0, done pulse 1 cycle.
- a=0xFF, b=0x01, cin=0, sub=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, overflow=1.
- Subtract:
  - a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0 (borrow), overflow=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- Start pulsed again during RUN with different operands → ignored; first result is unchanged. Start held during the DONE cycle with a=0x10, b=0x20 → second done 5 cycles later, sum=0x30.
- reset_n low for 1 cycle after chunk 2 of a=0xAA+0x55 → busy=0, done=0, sum=0 immediately; a new start then completes with the correct result (0xFF).
- Parameter sweep CHUNK=1, 4, 8 with random operands vs. a reference model → sum/cout/overflow match; done appears N+1 cycles after start acceptance.
